// File: rtl/lstm_gate_mac.sv
// Column-serial LSTM gate: gateOutput = act(Wx*x + Wy*y + b) over HIDDEN_SZ lanes.
// Optional feature macro GATE_PEEPHOLE_EN adds the cell-state peephole term and its two ports.
module lstm_gate_mac #(
  parameter int INPUT_SZ  = 2,
  parameter int HIDDEN_SZ = 16,
  parameter int QN        = 6,
  parameter int QM        = 11,
  parameter int ACC_GUARD = 4,
  localparam int BITWIDTH       = QN + QM + 1,
  localparam int ACCW           = BITWIDTH + ACC_GUARD,
  localparam int LAYER_BITWIDTH = BITWIDTH * HIDDEN_SZ,
  localparam int AX = (INPUT_SZ  > 2) ? $clog2(INPUT_SZ)  : 1,
  localparam int AY = (HIDDEN_SZ > 2) ? $clog2(HIDDEN_SZ) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      beginCalc,
  input  logic                      actMode,
  input  logic [BITWIDTH-1:0]       inputVec,
  input  logic [BITWIDTH-1:0]       prevOutVec,
  input  logic [LAYER_BITWIDTH-1:0] weightMemOutput_X,
  input  logic [LAYER_BITWIDTH-1:0] weightMemOutput_Y,
  input  logic [LAYER_BITWIDTH-1:0] biasVec,
  output logic [AX-1:0]             colAddressRead_X,
  output logic [AY-1:0]             colAddressRead_Y,
  output logic                      busy,
  output logic                      dataReady,
  output logic [LAYER_BITWIDTH-1:0] gateOutput
`ifdef GATE_PEEPHOLE_EN
  ,
  input  logic [LAYER_BITWIDTH-1:0] cellStateVec,
  input  logic [LAYER_BITWIDTH-1:0] peepholeVec
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_RUN_X, S_RUN_Y, S_BIAS, S_ACT} state_t;

  localparam logic [AX-1:0] X_LAST = AX'(INPUT_SZ - 1);
  localparam logic [AY-1:0] Y_LAST = AY'(HIDDEN_SZ - 1);
  localparam logic signed [BITWIDTH:0] C_ONE     = (BITWIDTH+1)'(2 ** QM);
  localparam logic signed [BITWIDTH:0] C_HALF    = (BITWIDTH+1)'(2 ** (QM - 1));
  localparam logic signed [BITWIDTH:0] C_NEG_ONE = -C_ONE;
  localparam logic signed [BITWIDTH:0] C_ZERO    = (BITWIDTH+1)'(0);

  state_t                     r_state;
  logic                       r_valid;
  logic                       r_src_y;
  logic                       r_act_mode;
  logic signed [ACCW-1:0]     r_acc      [HIDDEN_SZ];
  logic signed [BITWIDTH-1:0] r_pre      [HIDDEN_SZ];
  logic signed [ACCW-1:0]     w_acc_next [HIDDEN_SZ];
  logic signed [BITWIDTH-1:0] w_in;

  // Full-precision product rescaled to the accumulator grid (floor shift, then wrap).
  function automatic logic signed [ACCW-1:0] scale_prod(input logic signed [2*BITWIDTH-1:0] f);
    return ACCW'(f >>> QM);
  endfunction

  function automatic logic signed [BITWIDTH-1:0] sat_bw(input logic signed [ACCW-1:0] a);
    logic [ACC_GUARD:0] top;
    top = a[ACCW-1:BITWIDTH-1];
    if (top == {(ACC_GUARD+1){a[ACCW-1]}}) begin
      return a[BITWIDTH-1:0];
    end else if (a[ACCW-1]) begin
      return {1'b1, {(BITWIDTH-1){1'b0}}};
    end else begin
      return {1'b0, {(BITWIDTH-1){1'b1}}};
    end
  endfunction

  function automatic logic signed [BITWIDTH-1:0] activate(input logic signed [BITWIDTH-1:0] p,
                                                          input logic tanh_mode);
    logic signed [BITWIDTH:0] t;
    logic signed [BITWIDTH:0] lo;
    if (tanh_mode) begin
      t  = {p[BITWIDTH-1], p};
      lo = C_NEG_ONE;
    end else begin
      t  = ($signed({p[BITWIDTH-1], p}) >>> 2) + C_HALF;
      lo = C_ZERO;
    end
    if (t < lo) begin
      t = lo;
    end else if (t > C_ONE) begin
      t = C_ONE;
    end else begin
      t = t;
    end
    return t[BITWIDTH-1:0];
  endfunction

  assign w_in = r_src_y ? prevOutVec : inputVec;

  for (genvar g = 0; g < HIDDEN_SZ; g++) begin : g_lane
    logic signed [BITWIDTH-1:0]   w_wt;
    logic signed [2*BITWIDTH-1:0] w_prod_full;
    logic signed [ACCW-1:0]       w_prod;
    logic signed [ACCW-1:0]       w_bias;
    logic signed [ACCW-1:0]       w_peep;

    assign w_wt = r_src_y ? weightMemOutput_Y[g*BITWIDTH +: BITWIDTH]
                          : weightMemOutput_X[g*BITWIDTH +: BITWIDTH];
    assign w_prod_full = (2*BITWIDTH)'(w_wt) * (2*BITWIDTH)'(w_in);
    assign w_prod = r_valid ? scale_prod(w_prod_full) : {ACCW{1'b0}};
    assign w_bias = ACCW'($signed(biasVec[g*BITWIDTH +: BITWIDTH]));
`ifdef GATE_PEEPHOLE_EN
    logic signed [2*BITWIDTH-1:0] w_peep_full;
    assign w_peep_full = (2*BITWIDTH)'($signed(cellStateVec[g*BITWIDTH +: BITWIDTH]))
                       * (2*BITWIDTH)'($signed(peepholeVec[g*BITWIDTH +: BITWIDTH]));
    assign w_peep = scale_prod(w_peep_full);
`else
    assign w_peep = {ACCW{1'b0}};
`endif
    // The last Wy product is still in flight during BIAS, so bias folds in alongside it.
    assign w_acc_next[g] = r_acc[g] + w_prod
                         + ((r_state == S_BIAS) ? (w_bias + w_peep) : {ACCW{1'b0}});
  end

  // Sequencer: column addresses, the one-cycle-delayed valid pipe and status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_valid          <= 1'b0;
      r_src_y          <= 1'b0;
      r_act_mode       <= 1'b0;
      colAddressRead_X <= {AX{1'b0}};
      colAddressRead_Y <= {AY{1'b0}};
      busy             <= 1'b0;
      dataReady        <= 1'b0;
    end else begin
      dataReady <= 1'b0;
      r_valid   <= (r_state == S_RUN_X) || (r_state == S_RUN_Y);
      r_src_y   <= (r_state == S_RUN_Y);
      case (r_state)
        S_IDLE: begin
          if (beginCalc) begin
            r_state          <= S_RUN_X;
            r_act_mode       <= actMode;
            colAddressRead_X <= {AX{1'b0}};
            busy             <= 1'b1;
          end
        end
        S_RUN_X: begin
          if (colAddressRead_X == X_LAST) begin
            r_state          <= S_RUN_Y;
            colAddressRead_Y <= {AY{1'b0}};
          end else begin
            colAddressRead_X <= colAddressRead_X + AX'(1);
          end
        end
        S_RUN_Y: begin
          if (colAddressRead_Y == Y_LAST) begin
            r_state <= S_BIAS;
          end else begin
            colAddressRead_Y <= colAddressRead_Y + AY'(1);
          end
        end
        S_BIAS: r_state <= S_ACT;
        S_ACT: begin
          r_state   <= S_IDLE;
          busy      <= 1'b0;
          dataReady <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: per-lane accumulate, saturate to pre-activation, then activate.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < HIDDEN_SZ; i++) begin
        r_acc[i] <= {ACCW{1'b0}};
        r_pre[i] <= {BITWIDTH{1'b0}};
      end
      gateOutput <= {LAYER_BITWIDTH{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (beginCalc) begin
            for (int i = 0; i < HIDDEN_SZ; i++) r_acc[i] <= {ACCW{1'b0}};
          end
        end
        S_RUN_X, S_RUN_Y: begin
          for (int i = 0; i < HIDDEN_SZ; i++) r_acc[i] <= w_acc_next[i];
        end
        S_BIAS: begin
          for (int i = 0; i < HIDDEN_SZ; i++) begin
            r_acc[i] <= w_acc_next[i];
            r_pre[i] <= sat_bw(w_acc_next[i]);
          end
        end
        S_ACT: begin
          for (int i = 0; i < HIDDEN_SZ; i++) begin
            gateOutput[i*BITWIDTH +: BITWIDTH] <= activate(r_pre[i], r_act_mode);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lstm_gate_mac.sv
// Directed bench for lstm_gate_mac with registered weight/input RAM models.
module tb_lstm_gate_mac;
  localparam int IN  = 2;
  localparam int HID = 16;
  localparam int BW  = 18;
  localparam int LBW = BW * HID;

  logic           clock = 1'b0;
  logic           reset;
  logic           beginCalc;
  logic           actMode;
  logic [BW-1:0]  inputVec;
  logic [BW-1:0]  prevOutVec;
  logic [LBW-1:0] weightMemOutput_X;
  logic [LBW-1:0] weightMemOutput_Y;
  logic [LBW-1:0] biasVec;
  logic           colAddressRead_X;
  logic [3:0]     colAddressRead_Y;
  logic           busy;
  logic           dataReady;
  logic [LBW-1:0] gateOutput;

  logic [LBW-1:0] wx [IN];
  logic [LBW-1:0] wy [HID];
  logic [BW-1:0]  xv [IN];
  logic [BW-1:0]  yv [HID];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  lstm_gate_mac dut (
    .clock             (clock),
    .reset             (reset),
    .beginCalc         (beginCalc),
    .actMode           (actMode),
    .inputVec          (inputVec),
    .prevOutVec        (prevOutVec),
    .weightMemOutput_X (weightMemOutput_X),
    .weightMemOutput_Y (weightMemOutput_Y),
    .biasVec           (biasVec),
    .colAddressRead_X  (colAddressRead_X),
    .colAddressRead_Y  (colAddressRead_Y),
    .busy              (busy),
    .dataReady         (dataReady),
    .gateOutput        (gateOutput)
  );

  // Sources with one-cycle read latency.
  always @(posedge clock) begin
    weightMemOutput_X <= wx[colAddressRead_X];
    inputVec          <= xv[colAddressRead_X];
    weightMemOutput_Y <= wy[colAddressRead_Y];
    prevOutVec        <= yv[colAddressRead_Y];
  end

  function automatic logic [LBW-1:0] rep(input logic [BW-1:0] v);
    return {HID{v}};
  endfunction

  task automatic check(input string tag, input logic [LBW-1:0] got, input logic [LBW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [BW-1:0] wxv, input logic [BW-1:0] xval,
                      input logic [BW-1:0] wyv, input logic [BW-1:0] yval,
                      input logic [BW-1:0] bv);
    for (int i = 0; i < IN; i++) begin
      wx[i] = rep(wxv);
      xv[i] = xval;
    end
    for (int j = 0; j < HID; j++) begin
      wy[j] = rep(wyv);
      yv[j] = yval;
    end
    biasVec = rep(bv);
  endtask

  // Wx=0.5, x={1.0,2.0}, Wy=0.25, y=-0.125, b=-0.25 -> p = 1.5 - 0.5 - 0.25 = 0.75
  task automatic load_mixed();
    load(18'h00400, 18'h00000, 18'h00200, 18'h3FF00, 18'h3FE00);
    xv[0] = 18'h00800;
    xv[1] = 18'h01000;
  endtask

  // actMode is flipped after the start edge to confirm it was latched.
  task automatic begin_now(input logic mode);
    actMode   = mode;
    beginCalc = 1'b1;
    @(posedge clock);
    #1;
    beginCalc = 1'b0;
    actMode   = ~mode;
  endtask

  task automatic start_run(input logic mode);
    @(negedge clock);
    begin_now(mode);
  endtask

  task automatic wait_ready(input string tag, input logic [LBW-1:0] exp);
    int edges;
    int bad;
    edges = 0;
    bad   = 0;
    if (colAddressRead_X !== 1'b0 || busy !== 1'b1) bad++;
    while (edges < 40) begin
      @(posedge clock);
      #1;
      edges++;
      if (dataReady) break;
      if (edges == 1 && colAddressRead_X !== 1'b1) bad++;
      if (edges >= 2 && edges <= 17 && colAddressRead_Y !== 4'(edges - 2)) bad++;
      if (busy !== 1'b1) bad++;
    end
    check({tag, "_latency"}, edges, 20);
    check({tag, "_trace"}, bad, 0);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_out"}, gateOutput, exp);
  endtask

  initial begin
    logic [LBW-1:0] e;
    int pulses;
    int first;

    reset     = 1'b1;
    beginCalc = 1'b1;
    actMode   = 1'b0;
    load(18'h0, 18'h0, 18'h0, 18'h0, 18'h0);
    repeat (3) @(posedge clock);
    #1;
    check("rst_out", gateOutput, 0);
    check("rst_ready", dataReady, 0);
    check("rst_busy", busy, 0);
    check("rst_addr_x", colAddressRead_X, 0);
    check("rst_addr_y", colAddressRead_Y, 0);
    @(negedge clock);
    reset     = 1'b0;
    beginCalc = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_no_run", {dataReady, busy}, 0);

    load(18'h00800, 18'h00800, 18'h0, 18'h0, 18'h0);
    start_run(1'b1);
    wait_ready("ones_tanh", rep(18'h00800));

    load(18'h0, 18'h0, 18'h0, 18'h0, 18'h0);
    biasVec[0*BW +: BW] = 18'h00800;
    biasVec[1*BW +: BW] = 18'h3E000;
    biasVec[2*BW +: BW] = 18'h1FFFF;
    biasVec[3*BW +: BW] = 18'h3F800;
    e = rep(18'h00400);
    e[0*BW +: BW] = 18'h00600;
    e[1*BW +: BW] = 18'h00000;
    e[2*BW +: BW] = 18'h00800;
    e[3*BW +: BW] = 18'h00200;
    start_run(1'b0);
    wait_ready("bias_sig", e);

    load(18'h0, 18'h0, 18'h0F800, 18'h0, 18'h0);
    yv[0] = 18'h0F800;
    start_run(1'b1);
    wait_ready("sat_pos", rep(18'h00800));

    load(18'h0, 18'h0, 18'h30800, 18'h0, 18'h0);
    yv[0] = 18'h0F800;
    start_run(1'b1);
    wait_ready("sat_neg", rep(18'h3F800));

    // 16 * 961.0 wraps modulo 2^22 to a negative accumulator value.
    load(18'h0, 18'h0, 18'h0F800, 18'h0F800, 18'h0);
    start_run(1'b1);
    wait_ready("acc_wrap", rep(18'h3F800));

    load(18'h3FFFF, 18'h00001, 18'h0, 18'h0, 18'h0);
    start_run(1'b1);
    wait_ready("floor_shift", rep(18'h3FFFE));

    load_mixed();
    start_run(1'b0);
    wait_ready("mixed_sig", rep(18'h00580));

    start_run(1'b0);
    pulses = 0;
    first  = 0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clock);
      #1;
      if (dataReady) begin
        pulses++;
        if (first == 0) first = k;
      end
      beginCalc = (k == 5 || k == 19);
    end
    check("midpulse_count", pulses, 1);
    check("midpulse_edge", first, 20);
    check("midpulse_out", gateOutput, rep(18'h00580));

    load(18'h00800, 18'h00800, 18'h0, 18'h0, 18'h0);
    start_run(1'b1);
    wait_ready("b2b_first", rep(18'h00800));
    load(18'h0, 18'h0, 18'h0, 18'h0, 18'h0);
    begin_now(1'b0);
    wait_ready("b2b_second", rep(18'h00400));

    load_mixed();
    start_run(1'b0);
    repeat (8) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_out", gateOutput, 0);
    check("abort_addr", {colAddressRead_X, colAddressRead_Y}, 0);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      if (dataReady) pulses++;
      @(posedge clock);
      #1;
    end
    check("abort_no_ready", pulses, 0);
    start_run(1'b0);
    wait_ready("after_abort", rep(18'h00580));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/lstm_gate_mac.md
# lstm_gate_mac

Column-serial LSTM gate engine. It computes gateOutput = act(Wx·x + Wy·y + b) for HIDDEN_SZ lanes in signed fixed point Q(QN).(QM). Each cycle it streams one weight column from each of two weightRAM instances, plus the matching scalar input. It is the parametrised successor of the existing gate: generalised guard-bit accumulation, a run-time selectable hard-sigmoid/hard-tanh activation, and an optional peephole term. It sits between the weight RAMs and the LSTM cell-state update.

## Interface
- INPUT_SZ, 2, length of x; number of Wx columns
- HIDDEN_SZ, 16, lanes; length of y; number of Wy columns
- QN, 6, integer bits
- QM, 11, fraction bits; BITWIDTH = QN+QM+1
- ACC_GUARD, 4, extra accumulator MSBs; ACCW = BITWIDTH+ACC_GUARD
- Derived: LAYER_BITWIDTH = BITWIDTH·HIDDEN_SZ; AX = max(1,$clog2(INPUT_SZ)); AY = max(1,$clog2(HIDDEN_SZ))

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- beginCalc  in  1  start request; sampled only in IDLE
- actMode  in  1  0 = hard sigmoid, 1 = hard tanh; latched with beginCalc
- inputVec  in  BITWIDTH  x[colAddressRead_X], valid one cycle after the address
- prevOutVec  in  BITWIDTH  y[colAddressRead_Y], valid one cycle after the address
- weightMemOutput_X  in  LAYER_BITWIDTH  Wx column; lane i at [i·BITWIDTH +: BITWIDTH]; one-cycle read latency
- weightMemOutput_Y  in  LAYER_BITWIDTH  Wy column; same layout and latency
- biasVec  in  LAYER_BITWIDTH  per-lane bias; stable while busy
- colAddressRead_X  out  AX  Wx column / x index; registered
- colAddressRead_Y  out  AY  Wy column / y index; registered
- busy  out  1  high outside IDLE
- dataReady  out  1  one-cycle pulse when gateOutput is updated
- gateOutput  out  LAYER_BITWIDTH  activated result; held between updates

## Operation
- FSM: IDLE → RUN_X (INPUT_SZ cycles) → RUN_Y (HIDDEN_SZ cycles) → BIAS (1) → ACT (1) → IDLE.
- IDLE with beginCalc=1 at an edge:
  - clear the accumulators;
  - latch actMode;
  - set colAddressRead_X=0 and enter RUN_X.
- RUN_X: colAddressRead_X increments once per cycle through 0..INPUT_SZ-1. Leaving RUN_X sets colAddressRead_Y=0.
- RUN_Y: colAddressRead_Y steps through 0..HIDDEN_SZ-1.
- Accumulation runs on a one-cycle-delayed valid pipe, so the product for the address issued in cycle t is added at the end of cycle t+1.
  - Product: signed BITWIDTH×BITWIDTH → 2·BITWIDTH, then arithmetic shift right by QM (floor), then sign-extend/truncate to ACCW.
  - The accumulator wraps modulo 2^ACCW.
- BIAS cycle: acc += last Wy product + sign-extended bias. The result is then saturated to BITWIDTH as pre-activation p, clamping to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1].
- ACT cycle:
  - sigmoid: out = clamp((p>>>2) + 2^(QM-1), 0, 2^QM);
  - tanh: out = clamp(p, -2^QM, 2^QM).
  - The result is registered into gateOutput and dataReady is pulsed.
- beginCalc is ignored while busy. beginCalc in the dataReady cycle (FSM already in IDLE) starts a new run back-to-back.
- Address registers hold their final values after a run and reset to 0 only on reset.

## Timing
- Reset values: gateOutput=0, dataReady=0, busy=0, both addresses=0, FSM=IDLE, accumulators=0.
- Reset mid-run aborts immediately: the next cycle is IDLE with the reset values above, and no dataReady is produced.
- Latency: if beginCalc is sampled at edge E0, gateOutput and dataReady change at edge E0+INPUT_SZ+HIDDEN_SZ+2. With defaults this is 20 edges.
- busy rises after E0 and falls at the same edge dataReady rises.
- Sources must present data exactly one cycle after each address. The block has no stall or backpressure.

## Configuration
- GATE_PEEPHOLE_EN defined:
  - adds ports cellStateVec (in, LAYER_BITWIDTH) and peepholeVec (in, LAYER_BITWIDTH);
  - the BIAS cycle also adds the per-lane (c_i·p_i)>>>QM, computed as elementwise products in parallel;
  - latency is unchanged.
- Undefined: those ports and the peephole term are absent, and behaviour is exactly as above.

## Test plan
- Reset for 3 cycles → all outputs 0 and busy=0; beginCalc asserted during reset → no run.
- Wx all 1.0 (0x00800), x=1.0, Wy=0, b=0, tanh → every lane 0x00800, dataReady exactly 20 edges after beginCalc.
- All inputs zero, sigmoid → every lane 0x00400 (0.5). Bias lane 0 = 0x00800 (p=1.0) → lane 0 0x00600 (0.75). Bias lane 1 = -4.0 (0x3E000) → lane 1 0x00000.
- Overflow: Wy=31.0, y=31.0, tanh → p saturates to 0x1FFFF and output is 0x00800. Negated weights → 0x3F800 (-1.0).
- Address trace: colAddressRead_X 0,1, then colAddressRead_Y 0..15 in consecutive cycles. beginCalc pulsed mid-run → ignored, single dataReady. beginCalc on the dataReady cycle → second result 20 edges later.
- Reset asserted during RUN_Y → IDLE next cycle, gateOutput=0, no dataReady. A fresh run afterwards matches the golden results.
